// File: rtl/imem_fetch_ctrl_pkg.sv
// imem_pkg: shared FSM state encoding and instruction-memory sizing
package imem_pkg;
  localparam int INST_W = 32;
  localparam int DEFAULT_MEM_SIZE = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: memory read port, decode handshake and redirect bundle
interface imem_fetch_ctrl_if #(parameter int ADDR_W = 32);
  import imem_pkg::*;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic inst_valid;
  logic inst_ready;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  modport master (
    output imem_addr, inst, inst_pc, inst_valid,
    input  imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_addr, inst, inst_pc, inst_valid,
    output imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl_pc_next.sv
// imem_pc_next: sequential/redirect next-PC and bounds check (IMEM_BOUNDS_HALT_EN selects halt vs wrap)
module imem_pc_next #(
  parameter int MEM_SIZE = 16,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] seq_pc,
  output logic [ADDR_W-1:0] tgt_pc,
  output logic              oob
);
`ifdef IMEM_BOUNDS_HALT_EN
  assign seq_pc = pc + ADDR_W'(1);
  assign tgt_pc = redirect_pc;
  assign oob = pc >= ADDR_W'(MEM_SIZE);
`else
  assign seq_pc = (pc == ADDR_W'(MEM_SIZE - 1)) ? '0 : pc + ADDR_W'(1);
  assign tgt_pc = redirect_pc % ADDR_W'(MEM_SIZE);
  assign oob = 1'b0;
`endif
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC owner and fetch FSM feeding decode (IMEM_BOUNDS_HALT_EN enables end-of-program halt)
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter int ADDR_W = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic halted,
  imem_fetch_ctrl_if.master bus
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, inst_pc_q, inst_pc_d, seq_pc, tgt_pc;
  logic [INST_W-1:0] inst_q, inst_d;
  logic valid_q, valid_d, oob, fire;

  imem_pc_next #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) u_pc_next (
    .pc(pc_q),
    .redirect_pc(bus.redirect_pc),
    .seq_pc(seq_pc),
    .tgt_pc(tgt_pc),
    .oob(oob)
  );

  assign fire = !valid_q || bus.inst_ready;
  assign bus.imem_addr = pc_q;
  assign bus.inst = inst_q;
  assign bus.inst_pc = inst_pc_q;
  assign bus.inst_valid = valid_q;
  assign halted = state_q == HALT;

  // next state: redirect beats fetch/stall; a fire past the end halts instead of capturing
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        pc_d = ADDR_W'(RESET_PC);
      end
      RUN: if (bus.redirect_valid) begin
        pc_d = tgt_pc;
        valid_d = 1'b0;
      end else if (fire && oob) begin
        state_d = HALT;
        valid_d = 1'b0;
      end else if (fire) begin
        inst_d = bus.imem_rdata;
        inst_pc_d = pc_q;
        valid_d = 1'b1;
        pc_d = seq_pc;
      end
      HALT: valid_d = bus.inst_ready ? 1'b0 : valid_q;
      default: state_d = IDLE;
    endcase
  end

  // state and output register; reset drops any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= ADDR_W'(RESET_PC);
      inst_q <= '0;
      inst_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed vector table, corner sequences and random run against a reference model
module tb_imem_fetch_ctrl;
  import imem_pkg::*;
  localparam int MS = 16;
`ifdef IMEM_BOUNDS_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic halted;
  int checks = 0, errors = 0;

  imem_fetch_ctrl_if #(.ADDR_W(32)) bus ();
  imem_fetch_ctrl #(.MEM_SIZE(MS), .ADDR_W(32), .RESET_PC(0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .halted(halted),
    .bus(bus)
  );

  always #5 clk = ~clk;
  assign bus.imem_rdata = bus.imem_addr + 32'h100;

  typedef struct {
    bit st, rdy, rv;
    logic [31:0] rp;
    bit ev;
    logic [31:0] epc, eaddr;
    bit eh;
  } vec_t;
  vec_t tbl[$];

  int m_st;
  bit m_v;
  logic [31:0] m_pc, m_ipc, m_inst;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit s, bit r, bit rv, logic [31:0] rp);
    start = s;
    bus.inst_ready = r;
    bus.redirect_valid = rv;
    bus.redirect_pc = rp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(bit st, bit rdy, bit rv, int rp, bit ev, int epc, int eaddr, bit eh);
    vec_t v;
    v.st = st; v.rdy = rdy; v.rv = rv; v.rp = 32'(rp);
    v.ev = ev; v.epc = 32'(epc); v.eaddr = 32'(eaddr); v.eh = eh;
    return v;
  endfunction

  task automatic model_step(bit s, bit r, bit rv, logic [31:0] rp);
    if (m_st == 0) begin
      if (s) begin m_st = 1; m_pc = 0; end
    end else if (m_st == 1) begin
      if (rv) begin
        m_pc = HALT_EN ? rp : rp % MS;
        m_v = 0;
      end else if (!m_v || r) begin
        if (HALT_EN && m_pc >= MS) begin
          m_st = 2;
          m_v = 0;
        end else begin
          m_ipc = m_pc;
          m_inst = m_pc + 32'h100;
          m_v = 1;
          m_pc = HALT_EN ? m_pc + 1 : (m_pc + 1) % MS;
        end
      end
    end else if (r) m_v = 0;
  endtask

  task automatic model_reset();
    m_st = 0; m_v = 0; m_pc = 0; m_ipc = 0; m_inst = 0;
  endtask

  initial begin
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 2, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 3, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 3, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 3, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 3, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 4, 5, 0));
    tbl.push_back(mk(0, 0, 1, 9,  0, 0, 9, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 9, 10, 0));
    tbl.push_back(mk(0, 1, 1, 14, 0, 0, 14, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 14, 15, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 15, HALT_EN ? 16 : 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  !HALT_EN, 0, HALT_EN ? 16 : 1, HALT_EN));
    tbl.push_back(mk(0, 1, 0, 0,  !HALT_EN, 1, HALT_EN ? 16 : 2, HALT_EN));
    tbl.push_back(mk(0, 1, 1, 3,  0, 0, HALT_EN ? 16 : 3, HALT_EN));
    tbl.push_back(mk(0, 1, 1, 21, 0, 0, HALT_EN ? 16 : 5, HALT_EN));
    tbl.push_back(mk(0, 1, 0, 0,  !HALT_EN, 5, HALT_EN ? 16 : 6, HALT_EN));

    do_reset();
    chk("reset_valid", 32'(bus.inst_valid), 0);
    chk("reset_inst", bus.inst, 0);
    chk("reset_inst_pc", bus.inst_pc, 0);
    chk("reset_halted", 32'(halted), 0);
    chk("reset_addr", bus.imem_addr, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].rdy, tbl[i].rv, tbl[i].rp);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.inst_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, tbl[i].eaddr);
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(tbl[i].eh));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_inst_pc", i), bus.inst_pc, tbl[i].epc);
        chk($sformatf("vec%0d_inst", i), bus.inst, tbl[i].epc + 32'h100);
      end
    end

    do_reset();
    drive(1, 1, 0, 0);
    tick();
    drive(0, 1, 0, 0);
    repeat (3) tick();
    drive(0, 0, 0, 0);
    repeat (2) tick();
    chk("stall_valid", 32'(bus.inst_valid), 1);
    chk("stall_inst_pc", bus.inst_pc, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.inst_valid), 0);
    chk("async_rst_inst", bus.inst, 0);
    chk("async_rst_inst_pc", bus.inst_pc, 0);
    chk("async_rst_addr", bus.imem_addr, 0);
    chk("async_rst_halted", 32'(halted), 0);
    #1 rst_n = 1'b1;
    drive(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_no_fetch_valid", 32'(bus.inst_valid), 0);
      chk("idle_no_fetch_addr", bus.imem_addr, 0);
    end

    drive(0, 1, 1, 7);
    tick();
    chk("idle_redirect_addr", bus.imem_addr, 0);
    drive(1, 1, 1, 7);
    tick();
    chk("start_wins_addr", bus.imem_addr, 0);
    chk("start_wins_valid", 32'(bus.inst_valid), 0);
    drive(0, 1, 0, 0);
    tick();
    chk("first_inst_valid", 32'(bus.inst_valid), 1);
    chk("first_inst_pc", bus.inst_pc, 0);
    chk("first_inst", bus.inst, 32'h100);

    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit s, r, rv;
      logic [31:0] rp;
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
      end
      s = $urandom_range(0, 15) == 0;
      r = $urandom_range(0, 1) == 1;
      rv = $urandom_range(0, 7) == 0;
      rp = 32'($urandom_range(0, 31));
      drive(s, r, rv, rp);
      model_step(s, r, rv, rp);
      tick();
      chk("rand_valid", 32'(bus.inst_valid), 32'(m_v));
      chk("rand_addr", bus.imem_addr, m_pc);
      chk("rand_halted", 32'(halted), 32'(m_st == 2));
      if (m_v) begin
        chk("rand_inst_pc", bus.inst_pc, m_ipc);
        chk("rand_inst", bus.inst, m_inst);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
